s4ga_stream_core: RTL

// - Next-generation serial-configured LUT fabric: evaluates N K-input LUTs, one per config record, from a SI_W-bit stream.
// - Adds a valid-qualified (stallable) stream, absolute LUT addressing and registered outputs with a frame_done pulse.
// - Adds sticky index-range error detection; sits between the config/stream source and the chip I/O.

---
 rtl/s4ga_stream_core.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/s4ga_stream_core.sv
// s4ga_stream_core: K-input LUT fabric evaluated one record at a time from a stallable SI_W-bit stream.
// Optional macro S4GA_FF_EN: per-record mode segment marks a LUT registered until frame end.

module s4ga_stream_core #(
    parameter int N    = 64,
    parameter int K    = 4,
    parameter int I    = 4,
    parameter int O    = 8,
    parameter int SI_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            si_valid,
    input  logic [SI_W-1:0] si,
    input  logic [I-1:0]    inputs,
    output logic [O-1:0]    outputs,
    output logic            frame_done,
    output logic            lut_valid,
    output logic            lut_out,
    output logic            err
);
    localparam int IDX_W     = $clog2(3 + I + N);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int FLD_W     = IDX_SEGS * SI_W;
    localparam int MASK_W    = 2 ** K;
    localparam int MASK_SEGS = MASK_W / SI_W;
    localparam int SEG_MAX   = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    localparam int SEG_W     = $clog2(SEG_MAX + 1);
    localparam int N_W       = $clog2(N);
    localparam int K_W       = $clog2(K + 1);

    logic [N-1:0]      luts, luts_upd;
    logic              q;
    logic [I-1:0]      ins;
    logic [N_W-1:0]    n;
    logic [K_W-1:0]    k;
    logic [SEG_W-1:0]  seg;
    logic [FLD_W-1:0]  fld, fld_full;
    logic [K-1:0]      addr;
    logic [MASK_W-1:0] mask_sh, mask_full;
    logic              seg_ok, in_mask, idx_last, mask_last, frame_end;
    logic              idx_bit, idx_bad, value, half;
`ifdef S4GA_FF_EN
    logic [N-1:0]      pending, pend_upd, regd, regd_upd;
    logic              mode_phase, cur_reg;
`endif

    always_comb begin
`ifdef S4GA_FF_EN
        seg_ok = si_valid && !mode_phase;
`else
        seg_ok = si_valid;
`endif
        in_mask   = (k == K_W'(K));
        fld_full  = (fld << SI_W) | FLD_W'(si);
        mask_full = (mask_sh << SI_W) | MASK_W'(si);
        idx_last  = seg_ok && !in_mask && (seg == SEG_W'(IDX_SEGS - 1));
        mask_last = seg_ok && in_mask && (seg == SEG_W'(MASK_SEGS - 1));
        frame_end = mask_last && (n == N_W'(N - 1));
        value     = mask_full[addr];
        half      = mask_full[{1'b0, addr[K-2:0]}];
    end

    always_comb begin
        idx_bit = 1'b0;
        idx_bad = 1'b0;
        if (fld_full == FLD_W'(1))
            idx_bit = 1'b1;
        else if (fld_full == FLD_W'(2))
            idx_bit = q;
        else if ({1'b0, fld_full} >= (FLD_W + 1)'(3 + I + N))
            idx_bad = 1'b1;
        for (int unsigned j = 0; j < I; j++)
            if (fld_full == FLD_W'(3 + j)) idx_bit = ins[j];
        for (int unsigned j = 0; j < N; j++)
            if (fld_full == FLD_W'(3 + I + j)) idx_bit = luts[j];
    end

    // Registered LUTs park their value in pending and are folded into luts at frame end.
    always_comb begin
        luts_upd = luts;
`ifdef S4GA_FF_EN
        pend_upd = pending;
        regd_upd = regd;
        if (mask_last) begin
            regd_upd[n] = cur_reg;
            if (cur_reg) pend_upd[n] = value;
            else         luts_upd[n] = value;
        end
        if (frame_end)
            for (int unsigned i = 0; i < N; i++)
                if (regd_upd[i]) luts_upd[i] = pend_upd[i];
`else
        if (mask_last) luts_upd[n] = value;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luts       <= '0;
            q          <= 1'b0;
            ins        <= '0;
            n          <= '0;
            k          <= '0;
            seg        <= '0;
            fld        <= '0;
            addr       <= '0;
            mask_sh    <= '0;
            outputs    <= '0;
            frame_done <= 1'b0;
            lut_valid  <= 1'b0;
            lut_out    <= 1'b0;
            err        <= 1'b0;
`ifdef S4GA_FF_EN
            pending    <= '0;
            regd       <= '0;
            mode_phase <= 1'b1;
            cur_reg    <= 1'b0;
`endif
        end else begin
            ins        <= inputs;
            luts       <= luts_upd;
            lut_valid  <= mask_last;
            frame_done <= frame_end;
            if (mask_last) begin
                lut_out <= value;
                q       <= half;
            end
            if (frame_end) outputs <= luts_upd[N-1 -: O];
            if (idx_last && idx_bad) err <= 1'b1;
`ifdef S4GA_FF_EN
            pending <= pend_upd;
            regd    <= regd_upd;
            if (si_valid && mode_phase) begin
                cur_reg    <= si[0];
                mode_phase <= 1'b0;
            end
            if (mask_last) mode_phase <= 1'b1;
`endif
            if (seg_ok) begin
                if (!in_mask) begin
                    if (idx_last) begin
                        addr <= {addr[K-2:0], idx_bit};
                        fld  <= '0;
                        seg  <= '0;
                        k    <= k + 1'b1;
                    end else begin
                        fld <= fld_full;
                        seg <= seg + 1'b1;
                    end
                end else if (mask_last) begin
                    mask_sh <= '0;
                    seg     <= '0;
                    k       <= '0;
                    n       <= (n == N_W'(N - 1)) ? '0 : n + 1'b1;
                end else begin
                    mask_sh <= mask_full;
                    seg     <= seg + 1'b1;
                end
            end
        end
    end
endmodule
